lsu_split: RTL and testbench
============================

# lsu_split

Load/store sequencer between the execute datapath and the data-memory stage (DRAM plus load extender) of the RV32I core. Aligned accesses pass straight through in the same cycle. Misaligned halfword and word accesses are split into sequential byte accesses. The pipeline is stalled until the last byte, and load bytes are assembled and sign/zero-extended before writeback.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; every register updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req`  in  1  memory instruction present this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign field:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  32  effective byte address.
- `wdata`  in  32  store data from rs2.
- `mem_dout`  in  32  extended read data returned by the memory stage. Valid combinationally in the same cycle as `adr`.
- `adr`  out  32  memory byte address.
- `ram_w_op`  out  2  access width: 00 byte, 01 half, 10 word.
- `ram_we`  out  1  DRAM write enable. DRAM writes on the rising `clk` edge.
- `ram_wdin`  out  32  write data, right-aligned: byte = [7:0], half = [15:0].
- `mem_ext_op`  out  3  load extension. Same encoding as `funct3`.
- `stall`  out  1  hold PC and upstream stage registers.
- `load_data`  out  32  final load result for writeback.
- `load_valid`  out  1  `load_data` is valid this cycle.

## Operation
- **Misaligned condition:**
  - Halfword (001/101) with `addr[0]` = 1.
  - Word (010) with `addr[1:0]` ≠ 0.
  - Bytes are never misaligned.
- **Byte count n:** 2 for a halfword, 4 for a word.
- **Illegal funct3** (011, 110, 111): no access is made. `ram_we` = 0, `load_valid` = 0, `stall` = 0.
- **State `IDLE`, aligned request:**
  - Outputs are combinational pass-through: `adr` = `addr`, width from `funct3`, `ram_we` = `req_we`, `ram_wdin` = `wdata`, `mem_ext_op` = `funct3`.
  - For loads: `load_data` = `mem_dout` and `load_valid` = 1.
  - `stall` = 0.
- **State `IDLE`, misaligned request:**
  - Capture `addr`, `wdata`, `funct3` and `req_we` into base registers.
  - Issue byte k = 0 this cycle.
  - `stall` = 1. Go to `SPLIT` with k ← 1.
- **Every byte access k:**
  - `adr` = base + k, modulo 2^32.
  - `ram_w_op` = 00, `mem_ext_op` = 100 (LBU).
  - Store: `ram_we` = 1, `ram_wdin[7:0]` = stored `wdata[8k+7:8k]`, upper bits 0.
  - Load: `ram_we` = 0, and `mem_dout[7:0]` is written into byte lane k of the assembly buffer.
- **State `SPLIT`:**
  - Issue byte k from the captured registers. The live `req`, `addr` and `wdata` inputs are ignored.
  - If k < n−1: `stall` = 1, k ← k+1.
  - If k = n−1: `stall` = 0. For a load, `load_data` = buffer lanes 0..n−2 concatenated with the live `mem_dout[7:0]` in lane n−1, then extended:
    - LH: sign-extend from bit 15.
    - LHU: zero-extend from bit 15.
    - LW: no extension.
  - Also on k = n−1: `load_valid` = 1 for a load, 0 for a store. Return to `IDLE`.
- **Reset:**
  - State = `IDLE`, k = 0, assembly buffer = 0.
  - While `rst` = 1, all outputs are forced: `ram_we` = 0, `stall` = 0, `load_valid` = 0, `load_data` = 0, `adr` = 0, `ram_w_op` = 00, `ram_wdin` = 0, `mem_ext_op` = 000.
  - Reset asserted mid-`SPLIT` aborts the sequence. Bytes already written stay in DRAM; no further bytes are written.

## Timing
- **Aligned access:** 0 added latency. One cycle, fully combinational path from `addr` to `adr` and from `mem_dout` to `load_data`.
- **Misaligned halfword:** 2 cycles. `stall` is high in cycle 1 only.
- **Misaligned word:** 4 cycles. `stall` is high in cycles 1–3.
- **Load result:** `load_valid` pulses for exactly one cycle, the last cycle of the access, coincident with `stall` = 0.
- **Back-to-back requests:** the cycle after the return to `IDLE` accepts a new request with no bubble.
- **Stall contract:** upstream holds `req` while `stall` = 1. The block does not depend on that because it works only from captured values.
- **Address wrap:** a misaligned word at 0xFFFFFFFE accesses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.

## Test plan
- **Aligned word:** LW at 0x100 with DRAM word = 0xDEADBEEF → `adr` = 0x100, `ram_w_op` = 10, `load_data` = 0xDEADBEEF, `load_valid` = 1, `stall` = 0, same cycle.
- **Misaligned word store:** SW of 0x11223344 at 0x203 → 4 cycles. `adr` = 0x203, 0x204, 0x205, 0x206 with `ram_wdin` = 0x44, 0x33, 0x22, 0x11. `stall` sequence 1,1,1,0. A following aligned LW at 0x204 reads 0x00112233 in bits [23:0].
- **Misaligned halfword sign handling:** bytes 0x80 at 0x301 and 0xFF at 0x302:
  - LH at 0x301 → `load_data` = 0xFFFFFF80.
  - LHU at 0x301 → `load_data` = 0x0000FF80.
  - Both in 2 cycles; `load_valid` only in cycle 2.
- **Wrap-around:** LW at 0xFFFFFFFE → byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Result is assembled little-endian.
- **Reset mid-sequence:** assert `rst` in cycle 2 of SW at 0x401 → only byte 0x401 is written. In the cycle after `rst` deasserts, `stall` = 0, `ram_we` = 0 and the state is `IDLE`.
- **Illegal and back-to-back:** `funct3` = 011 with `req` = 1 → `ram_we` = 0, `load_valid` = 0. A misaligned LH immediately followed by an aligned SB → the SB issues in the cycle after the LH's `load_valid`.

Source files
------------

// File: rtl/lsu_split.sv
// Load/store sequencer: aligned accesses pass straight through, misaligned
// halfword/word accesses are split into byte accesses with the pipeline stalled.
module lsu_split (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_dout,
    output logic [31:0] adr,
    output logic [1:0]  ram_w_op,
    output logic        ram_we,
    output logic [31:0] ram_wdin,
    output logic [2:0]  mem_ext_op,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid
);

    // state | meaning
    // IDLE  | aligned pass-through, or byte 0 of a misaligned access
    // SPLIT | issuing byte k (k >= 1) of a misaligned access from captured registers
    typedef enum logic {IDLE, SPLIT} state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t      state;
    logic [1:0]  k;
    logic [31:0] base_addr;
    logic [31:0] base_wdata;
    logic [2:0]  base_f3;
    logic        base_we;
    logic [31:0] asm_buf;

    logic        legal;
    logic        misaligned;
    logic        start;
    logic [1:0]  last_k;
    logic        is_last;
    logic [7:0]  split_byte;
    logic [15:0] split_half;
    logic [31:0] split_word;

    always_comb begin
        legal      = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW)
                  || (funct3 == F3_LBU) || (funct3 == F3_LHU);
        misaligned = legal && (((funct3[1:0] == 2'b01) && addr[0])
                  || ((funct3 == F3_LW) && (addr[1:0] != 2'b00)));
        start      = (state == IDLE) && req && misaligned;
        last_k     = (base_f3 == F3_LW) ? 2'd3 : 2'd1;
        is_last    = (k == last_k);
        split_byte = base_wdata[{k, 3'b000} +: 8];
        // The final byte comes straight from the memory stage, not from the buffer.
        split_half = {mem_dout[7:0], asm_buf[7:0]};
        split_word = {mem_dout[7:0], asm_buf[23:0]};
    end

    always_comb begin
        adr        = 32'h0;
        ram_w_op   = 2'b00;
        ram_we     = 1'b0;
        ram_wdin   = 32'h0;
        mem_ext_op = 3'b000;
        stall      = 1'b0;
        load_data  = 32'h0;
        load_valid = 1'b0;
        if (!rst) begin
            if (state == SPLIT) begin
                adr        = base_addr + {30'h0, k};
                mem_ext_op = F3_LBU;
                ram_we     = base_we;
                ram_wdin   = {24'h0, split_byte};
                stall      = !is_last;
                if (is_last && !base_we) begin
                    load_valid = 1'b1;
                    case (base_f3)
                        F3_LW:   load_data = split_word;
                        F3_LH:   load_data = {{16{split_half[15]}}, split_half};
                        default: load_data = {16'h0, split_half};
                    endcase
                end
            end else if (req && legal) begin
                adr = addr;
                ram_we = req_we;
                if (misaligned) begin
                    mem_ext_op = F3_LBU;
                    ram_wdin   = {24'h0, wdata[7:0]};
                    stall      = 1'b1;
                end else begin
                    ram_w_op   = funct3[1:0];
                    ram_wdin   = wdata;
                    mem_ext_op = funct3;
                    if (!req_we) begin
                        load_data  = mem_dout;
                        load_valid = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= 2'd0;
            base_addr  <= 32'h0;
            base_wdata <= 32'h0;
            base_f3    <= 3'b000;
            base_we    <= 1'b0;
            asm_buf    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_addr  <= addr;
                        base_wdata <= wdata;
                        base_f3    <= funct3;
                        base_we    <= req_we;
                        k          <= 2'd1;
                        state      <= SPLIT;
                        if (!req_we)
                            asm_buf[7:0] <= mem_dout[7:0];
                    end
                end
                SPLIT: begin
                    if (!base_we)
                        asm_buf[{k, 3'b000} +: 8] <= mem_dout[7:0];
                    if (is_last) begin
                        k     <= 2'd0;
                        state <= IDLE;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                default: begin
                    k     <= 2'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_split.sv
// Self-checking bench for lsu_split: a byte-array DRAM driven by the DUT and an
// independent reference memory updated from the access semantics.
module tb_lsu_split;
    logic        clk = 1'b0;
    logic        rst, req, req_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_dout;
    logic [31:0] adr, ram_wdin, load_data;
    logic [1:0]  ram_w_op;
    logic        ram_we, stall, load_valid;
    logic [2:0]  mem_ext_op;

    int checks = 0;
    int failures = 0;

    logic [7:0] dram [logic [31:0]];
    logic [7:0] refm [logic [31:0]];

    lsu_split dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .mem_dout(mem_dout), .adr(adr),
        .ram_w_op(ram_w_op), .ram_we(ram_we), .ram_wdin(ram_wdin),
        .mem_ext_op(mem_ext_op), .stall(stall), .load_data(load_data),
        .load_valid(load_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dram_byte(input logic [31:0] a);
        return dram.exists(a) ? dram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 8'h00;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        case (w)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        dram[a] = v;
        refm[a] = v;
    endtask

    // Memory stage: combinational read of the DRAM at the DUT's address.
    task automatic settle();
        logic [31:0] raw;
        #1;
        raw = 32'h0;
        for (int i = 0; i < nbytes(ram_w_op); i++)
            raw[8*i +: 8] = dram_byte(adr + i);
        mem_dout = extend(mem_ext_op, raw);
        #1;
    endtask

    // DRAM captures the write present just before the rising edge.
    task automatic tick();
        if (ram_we)
            for (int i = 0; i < nbytes(ram_w_op); i++)
                dram[adr + i] = ram_wdin[8*i +: 8];
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] got);
        logic        legal, mis, e_stall, e_lv, e_we;
        logic [1:0]  e_wop;
        logic [2:0]  e_ext;
        logic [31:0] e_adr, e_wdin, e_ld;
        int          n, ncyc;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
        mis   = legal && (((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00)));
        n     = nbytes(f3[1:0]);
        ncyc  = mis ? n : 1;
        e_wop = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
        e_ld  = 32'h0;
        for (int i = 0; i < n; i++)
            e_ld[8*i +: 8] = ref_byte(a + i);
        e_ld = extend(f3, e_ld);
        got  = 32'hx;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                req = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
            end else begin
                req = 1'($urandom); req_we = 1'($urandom); funct3 = 3'($urandom);
                addr = $urandom; wdata = $urandom;
            end
            settle();
            e_stall = (c < ncyc - 1);
            e_lv    = legal && !we && (c == ncyc - 1);
            e_we    = legal && we;
            checks++;
            if (stall !== e_stall) begin
                failures++; $display("FAIL %s stall c%0d: got %b want %b", name, c, stall, e_stall);
            end
            checks++;
            if (load_valid !== e_lv) begin
                failures++; $display("FAIL %s load_valid c%0d: got %b want %b", name, c, load_valid, e_lv);
            end
            checks++;
            if (ram_we !== e_we) begin
                failures++; $display("FAIL %s ram_we c%0d: got %b want %b", name, c, ram_we, e_we);
            end
            if (legal) begin
                e_adr = mis ? a + c : a;
                e_ext = mis ? 3'b100 : f3;
                checks++;
                if (adr !== e_adr || ram_w_op !== (mis ? 2'b00 : e_wop) || mem_ext_op !== e_ext) begin
                    failures++;
                    $display("FAIL %s addr/op c%0d: got %h/%b/%b want %h/%b/%b", name, c,
                             adr, ram_w_op, mem_ext_op, e_adr, mis ? 2'b00 : e_wop, e_ext);
                end
                if (we) begin
                    e_wdin = mis ? {24'h0, wd[8*c +: 8]} : wd;
                    checks++;
                    if (ram_wdin !== e_wdin) begin
                        failures++; $display("FAIL %s ram_wdin c%0d: got %h want %h", name, c, ram_wdin, e_wdin);
                    end
                end
            end
            if (e_lv) begin
                got = load_data;
                checks++;
                if (load_data !== e_ld) begin
                    failures++; $display("FAIL %s load_data: got %h want %h", name, load_data, e_ld);
                end
            end
            tick();
        end
        if (legal && we)
            for (int i = 0; i < n; i++)
                refm[a + i] = wd[8*i +: 8];
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hCAFEF00D;
        mem_dout = 32'h0;
        tick(); tick();
        settle();
        checks++;
        if ({adr, ram_w_op, ram_we, ram_wdin, mem_ext_op, stall, load_data, load_valid} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got adr=%h wop=%b we=%b wdin=%h ext=%b st=%b ld=%h lv=%b want all 0",
                     adr, ram_w_op, ram_we, ram_wdin, mem_ext_op, stall, load_data, load_valid);
        end
        rst = 1'b0; req = 1'b0;
    endtask

    task automatic test_aligned_word();
        logic [31:0] g;
        poke(32'h100, 8'hEF); poke(32'h101, 8'hBE); poke(32'h102, 8'hAD); poke(32'h103, 8'hDE);
        do_access("lw100", 1'b0, 3'b010, 32'h100, 32'h0, g);
        checks++;
        if (g !== 32'hDEADBEEF) begin
            failures++; $display("FAIL lw100 value: got %h want deadbeef", g);
        end
    endtask

    task automatic test_misaligned_store();
        logic [31:0] g;
        do_access("sw203", 1'b1, 3'b010, 32'h203, 32'h11223344, g);
        do_access("lw204", 1'b0, 3'b010, 32'h204, 32'h0, g);
        checks++;
        if (g[23:0] !== 24'h112233) begin
            failures++; $display("FAIL lw204 value: got %h want 112233", g[23:0]);
        end
    endtask

    task automatic test_half_sign();
        logic [31:0] g;
        poke(32'h301, 8'h80); poke(32'h302, 8'hFF);
        do_access("lh301", 1'b0, 3'b001, 32'h301, 32'h0, g);
        checks++;
        if (g !== 32'hFFFFFF80) begin
            failures++; $display("FAIL lh301 value: got %h want ffffff80", g);
        end
        do_access("lhu301", 1'b0, 3'b101, 32'h301, 32'h0, g);
        checks++;
        if (g !== 32'h0000FF80) begin
            failures++; $display("FAIL lhu301 value: got %h want 0000ff80", g);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] g;
        poke(32'hFFFFFFFE, 8'h01); poke(32'hFFFFFFFF, 8'h02); poke(32'h0, 8'h03); poke(32'h1, 8'h04);
        do_access("lwwrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, g);
        checks++;
        if (g !== 32'h04030201) begin
            failures++; $display("FAIL lwwrap value: got %h want 04030201", g);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] g;
        poke(32'h401, 8'h5A); poke(32'h402, 8'h5A); poke(32'h403, 8'h5A);
        req = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h401; wdata = 32'hAABBCCDD;
        settle();
        checks++;
        if (adr !== 32'h401 || ram_we !== 1'b1 || ram_wdin !== 32'hDD || stall !== 1'b1) begin
            failures++;
            $display("FAIL rstmid byte0: got adr=%h we=%b wdin=%h st=%b want 401/1/dd/1", adr, ram_we, ram_wdin, stall);
        end
        tick();
        rst = 1'b1;
        settle();
        checks++;
        if (ram_we !== 1'b0 || stall !== 1'b0 || adr !== 32'h0) begin
            failures++; $display("FAIL rstmid in reset: got we=%b st=%b adr=%h want 0/0/0", ram_we, stall, adr);
        end
        tick();
        rst = 1'b0; req = 1'b0;
        settle();
        checks++;
        if (ram_we !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL rstmid after: got we=%b st=%b want 0/0", ram_we, stall);
        end
        checks++;
        if (dram_byte(32'h401) !== 8'hDD || dram_byte(32'h402) !== 8'h5A || dram_byte(32'h403) !== 8'h5A) begin
            failures++;
            $display("FAIL rstmid dram: got %h %h %h want dd 5a 5a",
                     dram_byte(32'h401), dram_byte(32'h402), dram_byte(32'h403));
        end
        refm[32'h401] = 8'hDD;
        do_access("lbidle", 1'b0, 3'b000, 32'h402, 32'h0, g);
    endtask

    task automatic test_illegal();
        logic [31:0] g;
        do_access("ill_st", 1'b1, 3'b011, 32'h600, 32'h12345678, g);
        do_access("ill_ld", 1'b0, 3'b110, 32'h601, 32'h0, g);
        do_access("lw600", 1'b0, 3'b010, 32'h600, 32'h0, g);
    endtask

    task automatic test_back_to_back();
        logic [31:0] g;
        poke(32'h701, 8'h34); poke(32'h702, 8'h12);
        do_access("lh701", 1'b0, 3'b001, 32'h701, 32'h0, g);
        do_access("sb710", 1'b1, 3'b000, 32'h710, 32'h000000AB, g);
        do_access("lb710", 1'b0, 3'b000, 32'h710, 32'h0, g);
        checks++;
        if (g !== 32'hFFFFFFAB) begin
            failures++; $display("FAIL lb710 value: got %h want ffffffab", g);
        end
    endtask

    task automatic test_random();
        logic [31:0] g, a;
        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                             : 32'h800 + $urandom_range(0, 15);
            do_access("rand", 1'($urandom), 3'($urandom), a, $urandom, g);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_misaligned_store();
        test_half_sign();
        test_wrap();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
